// File: rtl/wallace_mult.sv
// ============================================================================
// Module   : wallace_mult
// Purpose  : 32x32 unsigned Wallace-tree multiplier, combinational product c
//            plus a registered copy c_q.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module wallace_mult (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] c,
    output logic [63:0] c_q
);

    localparam int c_N_PP   = 32;
    localparam int c_NSTAGE = 8;

    // Row count after s stages of 3:2 reduction (groups of three rows become two).
    function automatic int rows_at(input int s);
        int n;
        n = c_N_PP;
        for (int i = 0; i < s; i++) begin
            n = (n / 3) * 2 + (n % 3);
        end
        return n;
    endfunction

    logic [63:0] w_pp [0:c_N_PP-1];
    logic [63:0] w_sum;

    genvar gi;
    generate
        for (gi = 0; gi < c_N_PP; gi++) begin : g_pp
            assign w_pp[gi] = {32'd0, (a & {32{b[gi]}})} << gi;
        end
    endgenerate

    genvar gs, gg, gr;
    generate
        for (gs = 0; gs < c_NSTAGE; gs++) begin : g_stage
            localparam int N_IN  = rows_at(gs);
            localparam int N_GRP = N_IN / 3;
            localparam int N_REM = N_IN % 3;
            localparam int N_OUT = rows_at(gs + 1);

            logic [63:0] w_in  [0:N_IN-1];
            logic [63:0] w_row [0:N_OUT-1];

            if (gs == 0) begin : g_src_pp
                for (gr = 0; gr < N_IN; gr++) begin : g_cp
                    assign w_in[gr] = w_pp[gr];
                end
            end else begin : g_src_prev
                for (gr = 0; gr < N_IN; gr++) begin : g_cp
                    assign w_in[gr] = g_stage[gs-1].w_row[gr];
                end
            end

            // Bitwise full adders per column; the carry shifted out of bit 63
            // is always zero because the exact product fits in 64 bits.
            for (gg = 0; gg < N_GRP; gg++) begin : g_fa
                assign w_row[2*gg]   = w_in[3*gg] ^ w_in[3*gg+1] ^ w_in[3*gg+2];
                assign w_row[2*gg+1] = ((w_in[3*gg]   & w_in[3*gg+1]) |
                                        (w_in[3*gg]   & w_in[3*gg+2]) |
                                        (w_in[3*gg+1] & w_in[3*gg+2])) << 1;
            end

            for (gr = 0; gr < N_REM; gr++) begin : g_pass
                assign w_row[2*N_GRP+gr] = w_in[3*N_GRP+gr];
            end
        end
    endgenerate

    assign w_sum = g_stage[c_NSTAGE-1].w_row[0] + g_stage[c_NSTAGE-1].w_row[1];
    assign c     = w_sum;

    logic [63:0] r_c_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_c_q <= 64'd0;
        end else begin
            r_c_q <= w_sum;
        end
    end

    assign c_q = r_c_q;

endmodule

`default_nettype wire

// File: tb/tb_wallace_mult.sv
// ============================================================================
// Module   : tb_wallace_mult
// Purpose  : Directed and back-to-back checks of wallace_mult c and c_q.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wallace_mult;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] c;
    logic [63:0] c_q;

    int vectors     = 0;
    int miscompares = 0;

    wallace_mult dut (
        .clock (clock),
        .reset (reset),
        .a     (a),
        .b     (b),
        .c     (c),
        .c_q   (c_q)
    );

    always #5 clock = ~clock;

    task automatic test_reset;
        reset = 1'b1;
        a     = 32'h1234_5678;
        b     = 32'h0000_0009;
        #1;
        vectors++;
        if (c_q !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_cq_initial: got %h expected %h", c_q, 64'd0);
        end
        @(posedge clock);
        #1;
        vectors++;
        if (c_q !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_cq_hold: got %h expected %h", c_q, 64'd0);
        end
        vectors++;
        if (c !== 64'h0000_0000_A3D7_0A38) begin
            miscompares++;
            $display("FAIL reset_c_tracks: got %h expected %h", c, 64'h0000_0000_A3D7_0A38);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_directed;
        logic [31:0] ta [0:6];
        logic [31:0] tb [0:6];
        logic [63:0] te [0:6];
        ta[0] = 32'h0000_0000; tb[0] = 32'hFFFF_FFFF; te[0] = 64'h0000_0000_0000_0000;
        ta[1] = 32'hFFFF_FFFF; tb[1] = 32'h0000_0000; te[1] = 64'h0000_0000_0000_0000;
        ta[2] = 32'hDEAD_BEEF; tb[2] = 32'h0000_0001; te[2] = 64'h0000_0000_DEAD_BEEF;
        ta[3] = 32'h8000_0000; tb[3] = 32'h0000_0002; te[3] = 64'h0000_0001_0000_0000;
        ta[4] = 32'hFFFF_FFFF; tb[4] = 32'hFFFF_FFFF; te[4] = 64'hFFFF_FFFE_0000_0001;
        ta[5] = 32'h0000_FFFF; tb[5] = 32'h0000_FFFF; te[5] = 64'h0000_0000_FFFE_0001;
        ta[6] = 32'h0001_0000; tb[6] = 32'h0001_0000; te[6] = 64'h0000_0001_0000_0000;
        for (int i = 0; i < 7; i++) begin
            @(negedge clock);
            a = ta[i];
            b = tb[i];
            #1;
            vectors++;
            if (c !== te[i]) begin
                miscompares++;
                $display("FAIL directed_c[%0d]: a=%h b=%h got %h expected %h",
                         i, ta[i], tb[i], c, te[i]);
            end
            @(posedge clock);
            #1;
            vectors++;
            if (c_q !== te[i]) begin
                miscompares++;
                $display("FAIL directed_cq[%0d]: got %h expected %h", i, c_q, te[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] exp_c;
        logic [63:0] prev;
        logic        have_prev;
        have_prev = 1'b0;
        prev      = 64'd0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clock);
            if (have_prev) begin
                vectors++;
                if (c_q !== prev) begin
                    miscompares++;
                    $display("FAIL b2b_cq[%0d]: got %h expected %h", i, c_q, prev);
                end
            end
            a     = $urandom;
            b     = $urandom;
            if (i % 16 == 0) a = 32'hFFFF_FFFF;
            exp_c = 64'(a) * 64'(b);
            #1;
            vectors++;
            if (c !== exp_c) begin
                miscompares++;
                $display("FAIL b2b_c[%0d]: a=%h b=%h got %h expected %h", i, a, b, c, exp_c);
            end
            prev      = exp_c;
            have_prev = 1'b1;
        end
        @(posedge clock);
        #1;
        vectors++;
        if (c_q !== prev) begin
            miscompares++;
            $display("FAIL b2b_cq_last: got %h expected %h", c_q, prev);
        end
    endtask

    task automatic test_registered_reset;
        @(negedge clock);
        a = 32'd3;
        b = 32'd5;
        @(posedge clock);
        #1;
        vectors++;
        if (c_q !== 64'd15) begin
            miscompares++;
            $display("FAIL reg_cq: got %0d expected 15", c_q);
        end
        @(negedge clock);
        reset = 1'b1;
        #1;
        vectors++;
        if (c_q !== 64'd0) begin
            miscompares++;
            $display("FAIL async_reset_cq: got %h expected 0", c_q);
        end
        vectors++;
        if (c !== 64'd15) begin
            miscompares++;
            $display("FAIL reset_c_stays: got %0d expected 15", c);
        end
        #1;
        reset = 1'b0;
        #1;
        vectors++;
        if (c_q !== 64'd0) begin
            miscompares++;
            $display("FAIL cq_after_release: got %h expected 0", c_q);
        end
        @(posedge clock);
        #1;
        vectors++;
        if (c_q !== 64'd15) begin
            miscompares++;
            $display("FAIL cq_reload: got %0d expected 15", c_q);
        end
    endtask

    initial begin
        reset = 1'b1;
        a     = 32'd0;
        b     = 32'd0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_registered_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
